stream_mux_rr: RTL and testbench

- Parametrised N-to-1 streaming multiplexer with round-robin arbitration and a registered output stage.
- Generalises the fixed 4-bit, 2^n-way select-driven mux. Channel selection is made internally, per transfer, by a fair arbiter rather than by an external `sel` input.
- Optional packet mode keeps the grant on one channel until its `last` beat has passed.
- Sits between several producer streams and a single consumer, for example a shared result bus.

---
 rtl/stream_mux_rr_pkg.sv | 16 +
 rtl/stream_mux_rr_if.sv | 33 +++
 rtl/stream_mux_rr_rr_arbiter.sv | 84 ++++++++
 rtl/stream_mux_rr.sv | 74 +++++++
 tb/tb_stream_mux_rr.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared constants for the round-robin stream multiplexer: defaults, lock-state
// encodings and the channel-index width helper.
package stream_mux_rr_pkg;

   localparam int unsigned DEF_N_CH = 4;
   localparam int unsigned DEF_W    = 4;

   localparam logic [0:0] ST_OPEN = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   // Index width for an N-way selector; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// N producer streams in, one registered consumer stream out.
// The slave modport is the multiplexer side.
interface stream_mux_rr_if
   import stream_mux_rr_pkg::*;
#(
   parameter int unsigned N_CH = DEF_N_CH,
   parameter int unsigned W    = DEF_W
) ();

   localparam int unsigned IDX_W = idx_width(N_CH);

   logic [N_CH-1:0]   in_valid;
   logic [N_CH*W-1:0] in_data;
   logic [N_CH-1:0]   in_last;
   logic [N_CH-1:0]   in_ready;

   logic              out_valid;
   logic [W-1:0]      out_data;
   logic              out_last;
   logic [IDX_W-1:0]  out_sel;
   logic              out_ready;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_sel
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_sel
   );

endinterface

// File: rtl/stream_mux_rr_rr_arbiter.sv
// Round-robin arbiter with optional packet lock. Owns the rotation pointer and
// the lock; the grant is combinational from req and the current state.
module rr_arbiter
   import stream_mux_rr_pkg::*;
#(
   parameter  int unsigned N_CH        = DEF_N_CH,
   parameter  int unsigned PACKET_MODE = 0,
   localparam int unsigned IDX_W       = idx_width(N_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  req,
   input  logic             advance,
   input  logic             last,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   localparam int unsigned SUM_W = IDX_W + 1;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [IDX_W-1:0] lock_idx;
   logic [IDX_W-1:0] lock_nxt;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_nxt;
   logic [SUM_W-1:0] cand_c;

   // Successor index, wrapping at N_CH even when N_CH is not a power of two.
   function automatic logic [IDX_W-1:0] next_of(input logic [IDX_W-1:0] i);
      return (32'(i) == N_CH - 1) ? '0 : i + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_OPEN;
         lock_idx <= '0;
         ptr      <= '0;
      end else begin
         state    <= state_nxt;
         lock_idx <= lock_nxt;
         ptr      <= ptr_nxt;
      end
   end

   // Grant search from ptr upward with wrap, or the locked channel only.
   always_comb begin
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand_c      = '0;
      state_nxt   = state;
      lock_nxt    = lock_idx;
      ptr_nxt     = ptr;

      if (state == ST_LOCK) begin
         grant_idx   = lock_idx;
         grant_valid = req[lock_idx];
      end else begin
         for (int unsigned k = 0; k < N_CH; k++) begin
            cand_c = SUM_W'(ptr) + SUM_W'(k);
            if (cand_c >= SUM_W'(N_CH)) cand_c = cand_c - SUM_W'(N_CH);
            if (!grant_valid && req[IDX_W'(cand_c)]) begin
               grant_valid = 1'b1;
               grant_idx   = IDX_W'(cand_c);
            end
         end
      end

      // Mid-packet beats park ptr on the owner; the lock release moves it on.
      if (advance) begin
         if (PACKET_MODE == 0) begin
            ptr_nxt = next_of(grant_idx);
         end else if (!last) begin
            state_nxt = ST_LOCK;
            lock_nxt  = grant_idx;
            ptr_nxt   = grant_idx;
         end else begin
            state_nxt = ST_OPEN;
            ptr_nxt   = next_of(grant_idx);
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer: round-robin arbiter in front of a single
// registered output stage that loads whenever it is empty or being drained.
module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter int unsigned N_CH        = DEF_N_CH,
   parameter int unsigned W           = DEF_W,
   parameter int unsigned PACKET_MODE = 0
) (
   input  logic           clk,
   input  logic           rst,
   stream_mux_rr_if.slave bus
);

   localparam int unsigned IDX_W = idx_width(N_CH);

   logic             load_en_c;
   logic             xfer_c;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic [W-1:0]     sel_data_c;
   logic             sel_last_c;
   logic [N_CH-1:0]  ready_c;

   assign load_en_c = !bus.out_valid || bus.out_ready;
   assign xfer_c    = load_en_c && grant_valid && !rst;

   rr_arbiter #(
      .N_CH        (N_CH),
      .PACKET_MODE (PACKET_MODE)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (bus.in_valid),
      .advance     (xfer_c),
      .last        (sel_last_c),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Granted channel's payload and its one-hot ready.
   always_comb begin
      sel_data_c = '0;
      sel_last_c = 1'b0;
      ready_c    = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            sel_data_c = bus.in_data[i*W +: W];
            sel_last_c = bus.in_last[i];
            ready_c[i] = xfer_c;
         end
      end
   end

   assign bus.in_ready = ready_c;

   // Output stage; payload fields hold when the register empties.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.out_sel   <= '0;
      end else if (load_en_c) begin
         bus.out_valid <= xfer_c;
         if (xfer_c) begin
            bus.out_data <= sel_data_c;
            bus.out_last <= sel_last_c;
            bus.out_sel  <= grant_idx;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios on three configurations, then
// random traffic against a queue-free behavioural model of the arbitration rules.
module tb_stream_mux_rr;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stream_mux_rr_if #(.N_CH(4), .W(4)) if_rr ();
   stream_mux_rr_if #(.N_CH(4), .W(4)) if_pk ();
   stream_mux_rr_if #(.N_CH(3), .W(8)) if_n3 ();

   stream_mux_rr #(.N_CH(4), .W(4), .PACKET_MODE(0)) u_rr (.clk(clk), .rst(rst), .bus(if_rr.slave));
   stream_mux_rr #(.N_CH(4), .W(4), .PACKET_MODE(1)) u_pk (.clk(clk), .rst(rst), .bus(if_pk.slave));
   stream_mux_rr #(.N_CH(3), .W(8), .PACKET_MODE(0)) u_n3 (.clk(clk), .rst(rst), .bus(if_n3.slave));

   // Per-DUT drive and observe arrays: 0 = rr, 1 = packet, 2 = three-channel.
   logic [3:0] v_valid  [3];
   logic [7:0] v_data   [3][4];
   logic [3:0] v_last   [3];
   logic       v_oready [3];

   logic [3:0] o_ready [3];
   logic       o_valid [3];
   logic [7:0] o_data  [3];
   logic       o_last  [3];
   logic [1:0] o_sel   [3];

   assign if_rr.in_valid  = v_valid[0];
   assign if_rr.in_data   = {v_data[0][3][3:0], v_data[0][2][3:0], v_data[0][1][3:0], v_data[0][0][3:0]};
   assign if_rr.in_last   = v_last[0];
   assign if_rr.out_ready = v_oready[0];
   assign if_pk.in_valid  = v_valid[1];
   assign if_pk.in_data   = {v_data[1][3][3:0], v_data[1][2][3:0], v_data[1][1][3:0], v_data[1][0][3:0]};
   assign if_pk.in_last   = v_last[1];
   assign if_pk.out_ready = v_oready[1];
   assign if_n3.in_valid  = v_valid[2][2:0];
   assign if_n3.in_data   = {v_data[2][2], v_data[2][1], v_data[2][0]};
   assign if_n3.in_last   = v_last[2][2:0];
   assign if_n3.out_ready = v_oready[2];

   assign o_ready[0] = if_rr.in_ready;
   assign o_valid[0] = if_rr.out_valid;
   assign o_data[0]  = {4'h0, if_rr.out_data};
   assign o_last[0]  = if_rr.out_last;
   assign o_sel[0]   = if_rr.out_sel;
   assign o_ready[1] = if_pk.in_ready;
   assign o_valid[1] = if_pk.out_valid;
   assign o_data[1]  = {4'h0, if_pk.out_data};
   assign o_last[1]  = if_pk.out_last;
   assign o_sel[1]   = if_pk.out_sel;
   assign o_ready[2] = {1'b0, if_n3.in_ready};
   assign o_valid[2] = if_n3.out_valid;
   assign o_data[2]  = if_n3.out_data;
   assign o_last[2]  = if_n3.out_last;
   assign o_sel[2]   = if_n3.out_sel;

   int checks = 0;
   int errors = 0;

   // Reference model state, one slot per DUT.
   int         nch [3] = '{4, 4, 3};
   bit         pm  [3] = '{1'b0, 1'b1, 1'b0};
   logic [7:0] msk [3] = '{8'h0F, 8'h0F, 8'hFF};
   int         m_ptr  [3];
   int         m_lock [3];
   int         m_xfer [3];
   bit         m_ov   [3];
   logic [7:0] m_od   [3];
   bit         m_ol   [3];
   int         m_os   [3];

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_all();
      for (int d = 0; d < 3; d++) begin
         v_valid[d]  = '0;
         v_last[d]   = '0;
         v_oready[d] = 1'b1;
         for (int c = 0; c < 4; c++) v_data[d][c] = '0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Channel the rules would grant now, or -1.
   function automatic int model_grant(int d);
      if (m_lock[d] >= 0) return v_valid[d][m_lock[d]] ? m_lock[d] : -1;
      for (int k = 0; k < nch[d]; k++) begin
         int c;
         c = (m_ptr[d] + k) % nch[d];
         if (v_valid[d][c]) return c;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         v_valid[d] = 4'hF;
         v_oready[d] = 1'b1;
      end
      for (int c = 0; c < 2; c++) begin
         #1;
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_ready[d] !== 4'b0000) begin
               errors++;
               $display("FAIL reset_ready dut%0d cyc%0d: got %b want 0000", d, c, o_ready[d]);
            end
         end
         step();
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (o_valid[d] !== 1'b0 || o_sel[d] !== 2'd0 || o_data[d] !== 8'h00 || o_last[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_out dut%0d: got v=%b sel=%0d data=%h last=%b want 0/0/00/0",
                     d, o_valid[d], o_sel[d], o_data[d], o_last[d]);
         end
      end
      rst = 1'b0;
      idle_all();
   endtask

   task automatic test_fairness();
      do_reset();
      v_valid[0] = 4'hF;
      for (int c = 0; c < 4; c++) v_data[0][c] = 8'(8'hA + c);
      #1;
      checks++;
      if (o_ready[0] !== 4'b0001) begin
         errors++;
         $display("FAIL fair_first_ready: got %b want 0001", o_ready[0]);
      end
      for (int k = 0; k < 8; k++) begin
         step();
         #1;
         checks++;
         if (o_valid[0] !== 1'b1 || o_sel[0] !== 2'(k % 4) || o_data[0] !== 8'(8'hA + k % 4)) begin
            errors++;
            $display("FAIL fair_beat%0d: got v=%b sel=%0d data=%h want 1/%0d/%h",
                     k, o_valid[0], o_sel[0], o_data[0], k % 4, 8'(8'hA + k % 4));
         end
         checks++;
         if (o_ready[0] !== 4'(1 << ((k + 1) % 4))) begin
            errors++;
            $display("FAIL fair_ready%0d: got %b want %b", k, o_ready[0], 4'(1 << ((k + 1) % 4)));
         end
      end
      idle_all();
   endtask

   task automatic test_backpressure();
      do_reset();
      v_valid[0] = 4'hF;
      for (int c = 0; c < 4; c++) v_data[0][c] = 8'(8'hA + c);
      v_oready[0] = 1'b0;
      #1;
      checks++;
      if (o_ready[0] !== 4'b0001) begin
         errors++;
         $display("FAIL bp_first_ready: got %b want 0001", o_ready[0]);
      end
      step();
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (o_valid[0] !== 1'b1 || o_data[0] !== 8'h0A || o_sel[0] !== 2'd0 || o_ready[0] !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b data=%h sel=%0d rdy=%b want 1/0a/0/0000",
                     k, o_valid[0], o_data[0], o_sel[0], o_ready[0]);
         end
         step();
      end
      v_oready[0] = 1'b1;
      #1;
      checks++;
      if (o_ready[0] !== 4'b0010) begin
         errors++;
         $display("FAIL bp_release_ready: got %b want 0010", o_ready[0]);
      end
      for (int k = 1; k < 3; k++) begin
         step();
         #1;
         checks++;
         if (o_valid[0] !== 1'b1 || o_sel[0] !== 2'(k) || o_data[0] !== 8'(8'hA + k)) begin
            errors++;
            $display("FAIL bp_after%0d: got v=%b sel=%0d data=%h want 1/%0d/%h",
                     k, o_valid[0], o_sel[0], o_data[0], k, 8'(8'hA + k));
         end
      end
      idle_all();
   endtask

   task automatic test_skip_wrap();
      do_reset();
      for (int c = 0; c < 4; c++) v_data[0][c] = 8'(5 + c);
      v_valid[0] = 4'b0010;
      #1;
      checks++;
      if (o_ready[0] !== 4'b0010) begin
         errors++;
         $display("FAIL skip_setup_ready: got %b want 0010", o_ready[0]);
      end
      step();
      v_valid[0] = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         int s;
         s = (k % 2 == 0) ? 3 : 1;
         #1;
         checks++;
         if (o_ready[0] !== 4'(1 << s)) begin
            errors++;
            $display("FAIL skip_ready%0d: got %b want %b", k, o_ready[0], 4'(1 << s));
         end
         step();
         #1;
         checks++;
         if (o_sel[0] !== 2'(s) || o_data[0] !== 8'(5 + s)) begin
            errors++;
            $display("FAIL skip_beat%0d: got sel=%0d data=%h want %0d/%h", k, o_sel[0], o_data[0], s, 8'(5 + s));
         end
      end
      idle_all();
   endtask

   task automatic test_packet();
      do_reset();
      v_valid[1] = 4'b0011;
      v_last[1]  = 4'b0010;
      v_data[1][0] = 8'h01;
      v_data[1][1] = 8'h09;
      #1;
      checks++;
      if (o_ready[1] !== 4'b0001) begin
         errors++;
         $display("FAIL pkt_b0_ready: got %b want 0001", o_ready[1]);
      end
      step();
      #1;
      checks++;
      if (o_valid[1] !== 1'b1 || o_sel[1] !== 2'd0 || o_last[1] !== 1'b0 || o_data[1] !== 8'h01) begin
         errors++;
         $display("FAIL pkt_b0_out: got v=%b sel=%0d last=%b data=%h want 1/0/0/01",
                  o_valid[1], o_sel[1], o_last[1], o_data[1]);
      end
      // Owner goes idle: the lock must still keep channel 1 out.
      v_valid[1] = 4'b0010;
      #1;
      checks++;
      if (o_ready[1] !== 4'b0000) begin
         errors++;
         $display("FAIL pkt_lock_idle_ready: got %b want 0000", o_ready[1]);
      end
      step();
      #1;
      checks++;
      if (o_valid[1] !== 1'b0 || o_sel[1] !== 2'd0 || o_data[1] !== 8'h01) begin
         errors++;
         $display("FAIL pkt_lock_idle_out: got v=%b sel=%0d data=%h want 0/0/01", o_valid[1], o_sel[1], o_data[1]);
      end
      for (int b = 1; b < 3; b++) begin
         v_valid[1] = 4'b0011;
         v_data[1][0] = 8'(1 + b);
         v_last[1][0] = (b == 2);
         #1;
         checks++;
         if (o_ready[1] !== 4'b0001) begin
            errors++;
            $display("FAIL pkt_b%0d_ready: got %b want 0001", b, o_ready[1]);
         end
         step();
         #1;
         checks++;
         if (o_valid[1] !== 1'b1 || o_sel[1] !== 2'd0 || o_last[1] !== (b == 2) || o_data[1] !== 8'(1 + b)) begin
            errors++;
            $display("FAIL pkt_b%0d_out: got v=%b sel=%0d last=%b data=%h want 1/0/%0d/%h",
                     b, o_valid[1], o_sel[1], o_last[1], o_data[1], (b == 2), 8'(1 + b));
         end
      end
      v_valid[1][0] = 1'b0;
      #1;
      checks++;
      if (o_ready[1] !== 4'b0010) begin
         errors++;
         $display("FAIL pkt_next_ready: got %b want 0010", o_ready[1]);
      end
      step();
      #1;
      checks++;
      if (o_sel[1] !== 2'd1 || o_data[1] !== 8'h09 || o_last[1] !== 1'b1) begin
         errors++;
         $display("FAIL pkt_next_out: got sel=%0d data=%h last=%b want 1/09/1", o_sel[1], o_data[1], o_last[1]);
      end
      idle_all();
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      v_valid[1] = 4'b0100;
      v_data[1][2] = 8'h0C;
      #1;
      checks++;
      if (o_ready[1] !== 4'b0100) begin
         errors++;
         $display("FAIL rmp_b1_ready: got %b want 0100", o_ready[1]);
      end
      step();
      v_valid[1] = 4'b0101;
      v_last[1]  = 4'b0001;
      v_data[1][0] = 8'h01;
      v_data[1][2] = 8'h0D;
      #1;
      checks++;
      if (o_ready[1] !== 4'b0100) begin
         errors++;
         $display("FAIL rmp_b2_ready: got %b want 0100", o_ready[1]);
      end
      step();
      #1;
      checks++;
      if (o_valid[1] !== 1'b1 || o_sel[1] !== 2'd2 || o_data[1] !== 8'h0D) begin
         errors++;
         $display("FAIL rmp_b2_out: got v=%b sel=%0d data=%h want 1/2/0d", o_valid[1], o_sel[1], o_data[1]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (o_ready[1] !== 4'b0000) begin
         errors++;
         $display("FAIL rmp_rst_ready: got %b want 0000", o_ready[1]);
      end
      step();
      rst = 1'b0;
      v_data[1][2] = 8'h0E;
      v_last[1]    = 4'b0101;
      #1;
      checks++;
      if (o_valid[1] !== 1'b0 || o_sel[1] !== 2'd0 || o_data[1] !== 8'h00) begin
         errors++;
         $display("FAIL rmp_rst_out: got v=%b sel=%0d data=%h want 0/0/00", o_valid[1], o_sel[1], o_data[1]);
      end
      checks++;
      if (o_ready[1] !== 4'b0001) begin
         errors++;
         $display("FAIL rmp_after_ready: got %b want 0001", o_ready[1]);
      end
      step();
      #1;
      checks++;
      if (o_valid[1] !== 1'b1 || o_sel[1] !== 2'd0 || o_data[1] !== 8'h01) begin
         errors++;
         $display("FAIL rmp_after_out: got v=%b sel=%0d data=%h want 1/0/01", o_valid[1], o_sel[1], o_data[1]);
      end
      idle_all();
   endtask

   task automatic test_non_pow2();
      do_reset();
      v_valid[2] = 4'b0111;
      for (int c = 0; c < 3; c++) v_data[2][c] = 8'(8'hA0 + 17 * c);
      #1;
      checks++;
      if (o_ready[2] !== 4'b0001) begin
         errors++;
         $display("FAIL np2_first_ready: got %b want 0001", o_ready[2]);
      end
      for (int k = 0; k < 7; k++) begin
         step();
         #1;
         checks++;
         if (o_sel[2] !== 2'(k % 3) || o_data[2] !== 8'(8'hA0 + 17 * (k % 3))) begin
            errors++;
            $display("FAIL np2_beat%0d: got sel=%0d data=%h want %0d/%h",
                     k, o_sel[2], o_data[2], k % 3, 8'(8'hA0 + 17 * (k % 3)));
         end
         checks++;
         if (o_ready[2] !== 4'(1 << ((k + 1) % 3))) begin
            errors++;
            $display("FAIL np2_ready%0d: got %b want %b", k, o_ready[2], 4'(1 << ((k + 1) % 3)));
         end
      end
      idle_all();
   endtask

   task automatic test_random(int cycles);
      idle_all();
      do_reset();
      for (int d = 0; d < 3; d++) begin
         m_ptr[d] = 0; m_lock[d] = -1; m_xfer[d] = -1;
         m_ov[d] = 1'b0; m_od[d] = '0; m_ol[d] = 1'b0; m_os[d] = 0;
      end
      for (int cyc = 0; cyc < cycles; cyc++) begin
         rst = ($urandom_range(0, 149) == 0);
         // Producers hold a pending beat until it is taken; consumer is free.
         for (int d = 0; d < 3; d++) begin
            v_oready[d] = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < nch[d]; c++) begin
               if (!v_valid[d][c] || m_xfer[d] == c) begin
                  v_valid[d][c] = ($urandom_range(0, 2) != 0);
                  v_data[d][c]  = 8'($urandom) & msk[d];
                  v_last[d][c]  = ($urandom_range(0, 2) == 0);
               end
            end
         end
         #1;
         for (int d = 0; d < 3; d++) begin
            bit         le;
            int         g;
            logic [3:0] exp_rdy;
            checks++;
            if (o_valid[d] !== m_ov[d] || o_data[d] !== m_od[d] || o_last[d] !== m_ol[d] || o_sel[d] !== 2'(m_os[d])) begin
               errors++;
               $display("FAIL rand_out dut%0d cyc%0d: got v=%b data=%h last=%b sel=%0d want %b/%h/%b/%0d",
                        d, cyc, o_valid[d], o_data[d], o_last[d], o_sel[d], m_ov[d], m_od[d], m_ol[d], m_os[d]);
            end
            le = !m_ov[d] || v_oready[d];
            g  = model_grant(d);
            exp_rdy = (le && g >= 0 && !rst) ? 4'(1 << g) : 4'b0000;
            checks++;
            if (o_ready[d] !== exp_rdy) begin
               errors++;
               $display("FAIL rand_ready dut%0d cyc%0d: got %b want %b", d, cyc, o_ready[d], exp_rdy);
            end
            m_xfer[d] = -1;
            if (rst) begin
               m_ptr[d] = 0; m_lock[d] = -1;
               m_ov[d] = 1'b0; m_od[d] = '0; m_ol[d] = 1'b0; m_os[d] = 0;
            end else if (le) begin
               if (g >= 0) begin
                  m_xfer[d] = g;
                  m_ov[d] = 1'b1; m_od[d] = v_data[d][g]; m_ol[d] = v_last[d][g]; m_os[d] = g;
                  if (!pm[d]) m_ptr[d] = (g + 1) % nch[d];
                  else if (!v_last[d][g]) begin
                     m_lock[d] = g; m_ptr[d] = g;
                  end else begin
                     m_lock[d] = -1; m_ptr[d] = (g + 1) % nch[d];
                  end
               end else begin
                  m_ov[d] = 1'b0;
               end
            end
         end
         step();
      end
      rst = 1'b0;
   endtask

   initial begin
      idle_all();
      @(negedge clk);
      test_reset();
      test_fairness();
      test_backpressure();
      test_skip_wrap();
      test_packet();
      test_reset_mid_packet();
      test_non_pow2();
      test_random(2000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
